// File: rtl/stopwatch_core_v2_if.sv
// Control and display bundle for stopwatch_core_v2: control pulses in, BCD digits and status out.
interface stopwatch_core_v2_if;
  logic       run_tgl;
  logic       clr;
  logic [1:0] mode;
  logic       adj_min;
  logic       lap;
  logic [3:0] sec_u;
  logic [3:0] sec_t;
  logic [3:0] min_u;
  logic [3:0] min_t;
  logic       running;
  logic       lap_active;
  logic       alarm;
  logic       tick;

  modport master (
    output run_tgl, clr, mode, adj_min, lap,
    input  sec_u, sec_t, min_u, min_t, running, lap_active, alarm, tick
  );

  modport slave (
    input  run_tgl, clr, mode, adj_min, lap,
    output sec_u, sec_t, min_u, min_t, running, lap_active, alarm, tick
  );
endinterface

// File: rtl/stopwatch_core_v2.sv
// Single-clock BCD mm:ss stopwatch/timer with prescaler strobes, adjust, countdown alarm and lap freeze.
module stopwatch_core_v2 #(
  parameter int unsigned TICK_CYCLES = 100000000,
  parameter int unsigned MIN_MAX     = 59,
  parameter bit          CD_WRAP     = 1'b0,
  parameter int unsigned ALARM_TICKS = 4
) (
  input logic                src_clk,
  input logic                src_rst_n,
  stopwatch_core_v2_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_CYCLES);
  localparam int unsigned AW = $clog2(ALARM_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_CYCLES / 2 - 1);
  localparam logic [3:0] MAX_MT = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_MU = 4'(MIN_MAX % 10);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_ADJ  = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'b00,
    ST_RUNNING = 2'b01,
    ST_ALARM   = 2'b10
  } run_state_e;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
  } bcd_time_t;

  function automatic bcd_time_t min_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.mt == MAX_MT && t.mu == MAX_MU) begin
      r.mt = '0;
      r.mu = '0;
    end else if (t.mu == 4'd9) begin
      r.mu = '0;
      r.mt = t.mt + 4'd1;
    end else begin
      r.mu = t.mu + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_time_t sec_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.su != 4'd9) begin
      r.su = t.su + 4'd1;
    end else begin
      r.su = '0;
      r.st = (t.st == 4'd5) ? 4'd0 : t.st + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_time_t time_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.su != 4'd0) begin
      r.su = t.su - 4'd1;
    end else begin
      r.su = 4'd9;
      if (t.st != 4'd0) begin
        r.st = t.st - 4'd1;
      end else begin
        r.st = 4'd5;
        if (t.mu != 4'd0) begin
          r.mu = t.mu - 4'd1;
        end else begin
          r.mu = 4'd9;
          r.mt = t.mt - 4'd1;
        end
      end
    end
    return r;
  endfunction

  logic [PW-1:0] presc_q;
  logic [AW-1:0] alarm_cnt_q;
  bcd_time_t     live_q;
  bcd_time_t     live_nxt;
  bcd_time_t     lap_q;
  bcd_time_t     shown;
  logic          lap_active_q;
  logic          tick_w;
  logic          half_w;
  logic          step_en;
  logic          expire;
  logic          alarm_done;
  mode_e         mode_w;
  run_state_e    state_q;
  run_state_e    state_nxt;

  always_comb begin
    mode_w  = mode_e'(bus.mode);
    tick_w  = (presc_q == PRESC_LAST);
    half_w  = tick_w || (presc_q == PRESC_HALF);
    step_en = 1'b0;
    if (state_q == ST_RUNNING) begin
      unique case (mode_w)
        MODE_UP, MODE_DOWN: step_en = tick_w;
        MODE_ADJ:           step_en = half_w;
        default:            step_en = 1'b0;
      endcase
    end
  end

  // Time datapath; expire flags a countdown reaching (or stepping at) 00:00 without wrap.
  always_comb begin
    live_nxt = live_q;
    expire   = 1'b0;
    if (step_en) begin
      unique case (mode_w)
        MODE_UP: begin
          live_nxt = sec_inc(live_q);
          if (live_q.st == 4'd5 && live_q.su == 4'd9) live_nxt = min_inc(live_nxt);
        end
        MODE_ADJ: live_nxt = bus.adj_min ? min_inc(live_q) : sec_inc(live_q);
        MODE_DOWN: begin
          if (live_q == '0) begin
            if (CD_WRAP) begin
              live_nxt.mt = MAX_MT;
              live_nxt.mu = MAX_MU;
              live_nxt.st = 4'd5;
              live_nxt.su = 4'd9;
            end else begin
              expire = 1'b1;
            end
          end else begin
            live_nxt = time_dec(live_q);
            if (live_nxt == '0 && !CD_WRAP) expire = 1'b1;
          end
        end
        default: live_nxt = live_q;
      endcase
    end
  end

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      presc_q      <= '0;
      live_q       <= '0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
    end else if (bus.clr) begin
      presc_q      <= '0;
      live_q       <= '0;
      lap_active_q <= 1'b0;
    end else begin
      presc_q <= tick_w ? '0 : presc_q + PW'(1);
      live_q  <= live_nxt;
      if (bus.lap) begin
        if (!lap_active_q) lap_q <= live_q;
        lap_active_q <= ~lap_active_q;
      end
    end
  end

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      alarm_cnt_q <= '0;
    end else if (state_q != ST_ALARM && state_nxt == ST_ALARM) begin
      alarm_cnt_q <= AW'(ALARM_TICKS);
    end else if (state_q == ST_ALARM && tick_w) begin
      alarm_cnt_q <= alarm_cnt_q - AW'(1);
    end
  end

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) state_q <= ST_PAUSED;
    else            state_q <= state_nxt;
  end

  // running and alarm are mutually exclusive, so they share one state register.
  always_comb begin
    state_nxt  = state_q;
    alarm_done = tick_w && (alarm_cnt_q == AW'(1));
    if (bus.clr) begin
      if (state_q == ST_ALARM) state_nxt = ST_PAUSED;
    end else begin
      unique case (state_q)
        ST_PAUSED: if (bus.run_tgl) state_nxt = ST_RUNNING;
        ST_RUNNING: begin
          if (expire)           state_nxt = ST_ALARM;
          else if (bus.run_tgl) state_nxt = ST_PAUSED;
        end
        ST_ALARM: begin
          if (bus.run_tgl)     state_nxt = ST_RUNNING;
          else if (alarm_done) state_nxt = ST_PAUSED;
        end
        default: state_nxt = ST_PAUSED;
      endcase
    end
  end

  always_comb begin
    shown          = lap_active_q ? lap_q : live_q;
    bus.sec_u      = shown.su;
    bus.sec_t      = shown.st;
    bus.min_u      = shown.mu;
    bus.min_t      = shown.mt;
    bus.running    = (state_q == ST_RUNNING);
    bus.alarm      = (state_q == ST_ALARM);
    bus.lap_active = lap_active_q;
    bus.tick       = tick_w;
  end

endmodule

// File: doc/stopwatch_core_v2.md
Name: stopwatch_core_v2

Overview:
- Parametrised single-clock stopwatch/timer core for the next-generation display path.
- Replaces derived 1/2 Hz clocks with an internal prescaler and clock-enable strobes.
- Counts directly in BCD (mm:ss), so no binary-to-digit divider is needed.
- Adds programmable minute limit, countdown alarm, optional countdown wrap, and lap freeze. Outputs feed the existing 7-segment mux.

Parameters:
- TICK_CYCLES, 100000000: src_clk cycles per count tick. Must be even and ≥ 2.
- MIN_MAX, 59: highest minute value, legal 1..99. The time wraps after MIN_MAX:59.
- CD_WRAP, 0: countdown behaviour at 00:00. 0 = stop and alarm; 1 = wrap to MIN_MAX:59 with no alarm.
- ALARM_TICKS, 4: number of full ticks the alarm stays asserted.

Ports:
- src_clk  in  1  system clock
- src_rst_n  in  1  asynchronous active-low reset
- run_tgl  in  1  single-cycle debounced pulse; toggles running
- clr  in  1  single-cycle synchronous clear pulse
- mode  in  2  00 = up, 01 = adjust, 10 = down, 11 = hold
- adj_min  in  1  in adjust mode: 1 steps minutes, 0 steps seconds
- lap  in  1  single-cycle pulse; toggles lap freeze
- sec_u  out  4  displayed seconds units (BCD)
- sec_t  out  4  displayed seconds tens (BCD, 0..5)
- min_u  out  4  displayed minutes units (BCD)
- min_t  out  4  displayed minutes tens (BCD)
- running  out  1  counter enabled
- lap_active  out  1  display frozen at the lap value
- alarm  out  1  countdown-expired indication
- tick  out  1  one-cycle strobe per full tick; used for blink

Behaviour:
- Reset (src_rst_n low, asynchronous):
  - all digits 0, prescaler 0
  - running = 0 (starts paused)
  - lap_active = 0, alarm = 0, tick = 0
- Prescaler: counts 0..TICK_CYCLES-1, then wraps.
  - tick = 1 for the cycle in which the prescaler equals TICK_CYCLES-1.
  - half strobe = 1 when the prescaler equals TICK_CYCLES/2-1 or TICK_CYCLES-1.
  - The prescaler runs freely regardless of running and mode. Only clr resets it.
- Step enable:
  - Modes 00 and 10 step on tick while running = 1.
  - Mode 01 steps on the half strobe (double rate) while running = 1.
  - Mode 11 never steps.
  - A mode change takes effect at the next strobe; the prescaler is undisturbed.
- Up step: BCD increment with carries.
  - sec_u 9 to 0 carries into sec_t.
  - sec_t 5 to 0 carries into minutes.
  - MIN_MAX:59 goes to 00:00.
- Adjust step, adj_min = 0: seconds +1, 59 wraps to 00, no carry into minutes.
- Adjust step, adj_min = 1: minutes +1, MIN_MAX wraps to 00, seconds unchanged.
- Down step: BCD decrement with borrows.
  - If the result is 00:00 and CD_WRAP = 0: clear running, set alarm.
  - A down step taken at 00:00 with CD_WRAP = 0: time stays 00:00, running clears, alarm sets.
  - A down step at 00:00 with CD_WRAP = 1: load MIN_MAX:59, no alarm.
- Alarm:
  - Deasserts after ALARM_TICKS ticks have elapsed since it was set.
  - Also clears on run_tgl or clr.
- run_tgl: running <= ~running. Any step in the same cycle uses the pre-toggle running value.
- clr:
  - Digits go to 0, prescaler to 0, alarm to 0, lap_active to 0.
  - running is unchanged.
  - clr has highest priority: run_tgl, lap and any step in the same cycle are ignored.
- lap:
  - When lap_active = 0: capture the live digits into the lap register and set lap_active = 1.
  - When lap_active = 1: set lap_active = 0.
  - A step in the same cycle as a capture: the captured value is the pre-step value.
  - Live counting continues during a freeze.
- Outputs:
  - When lap_active = 1, the digit outputs show the lap register; otherwise they show the live counters.
  - The outputs are a combinational mux of registers, so an update is visible in the cycle after the enabling edge.
- Invariants:
  - Every digit is always a legal BCD value.
  - Minutes never exceed MIN_MAX.

Test Plan (TICK_CYCLES = 4, MIN_MAX = 59 unless stated):
- Reset, then run_tgl, mode 00, run 61 ticks -> digits 01:01, running = 1, tick once every 4 cycles.
- Preload 59:59 via adjust, mode 00, one tick -> 00:00. Repeat with MIN_MAX = 2 at 02:59 -> 00:00.
- Mode 01, adj_min = 1, running, 8 cycles -> minutes +4 (half-strobe rate). Seconds at 59 with adj_min = 0, one step -> 00, minutes unchanged.
- Mode 10 at 00:02, CD_WRAP = 0, 2 ticks -> 00:00, running = 0, alarm high for exactly 4 ticks. Same with CD_WRAP = 1, 3 ticks -> 59:59, alarm stays 0.
- Lap at 00:05, 3 more ticks -> outputs hold 00:05 with lap_active = 1. Second lap -> outputs show 00:08.
- clr, run_tgl and lap asserted in the same cycle -> 00:00, running unchanged, lap_active = 0. src_rst_n low mid-count -> all outputs 0 immediately, without waiting for a clock edge.
